// File: rtl/bsort_pkg.sv
// ---------------------------------------------------------------------------
// bsort_pkg
// Shared definitions for the bubble-sort sequencer:
//   - default element / address widths
//   - minimum length that needs any sorting work
//   - one-hot state encoding of the sequencer FSM
// ---------------------------------------------------------------------------
package bsort_pkg;

  localparam int BSORT_DATA_W = 32;
  localparam int BSORT_ADDR_W = 8;
  localparam int MIN_SORT_LEN = 2;

  typedef enum logic [9:0] {
    S_IDLE     = 10'b00_0000_0001,
    S_SETUP    = 10'b00_0000_0010,
    S_RD_A     = 10'b00_0000_0100,
    S_RD_B     = 10'b00_0000_1000,
    S_CMP      = 10'b00_0001_0000,
    S_WR_A     = 10'b00_0010_0000,
    S_WR_B     = 10'b00_0100_0000,
    S_NEXT     = 10'b00_1000_0000,
    S_PASS_END = 10'b01_0000_0000,
    S_DONE     = 10'b10_0000_0000
  } state_e;

endpackage

// File: rtl/bsort_index_ctr.sv
// ---------------------------------------------------------------------------
// bsort_index_ctr
// Pair index (idx) and pass limit (limit) registers of the bubble sort.
// Ports:
//   clock, reset   : clock, asynchronous active-low reset
//   load           : start of sort: limit <= length, idx <= 0
//   next_pass      : new pass:      limit <= limit-1, idx <= 0
//   inc            : advance to the next pair: idx <= idx+1
//   length         : element count to load
//   idx, limit     : current register values
//   idx_nxt        : value idx takes at the next edge (used for
//                    registering the RAM address one cycle ahead)
//   last_pair      : idx+1 == limit-1, i.e. the current pair ends the pass
//   limit_gt2      : another pass can still shrink the range
// ---------------------------------------------------------------------------
module bsort_index_ctr
  import bsort_pkg::*;
#(
  parameter int ADDR_W = BSORT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              next_pass,
  input  logic              inc,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] idx_nxt,
  output logic [ADDR_W-1:0] limit,
  output logic              last_pair,
  output logic              limit_gt2
);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] limit_q, limit_d;

  // NOTE: every signal gets a default before the conditional updates, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_d   = idx_q;
    limit_d = limit_q;
    if (load) begin
      limit_d = length;
      idx_d   = '0;
    end else if (next_pass) begin
      limit_d = limit_q - ADDR_W'(1);
      idx_d   = '0;
    end else if (inc) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      limit_q <= '0;
    end else begin
      idx_q   <= idx_d;
      limit_q <= limit_d;
    end
  end

  assign idx       = idx_q;
  assign idx_nxt   = idx_d;
  assign limit     = limit_q;
  // limit never exceeds 2^ADDR_W-1, so idx+1 cannot wrap here.
  assign last_pair = (idx_q + ADDR_W'(1)) == (limit_q - ADDR_W'(1));
  assign limit_gt2 = limit_q > ADDR_W'(MIN_SORT_LEN);

endmodule

// File: rtl/bubble_sort_control.sv
// ---------------------------------------------------------------------------
// bubble_sort_control
// In-place ascending (unsigned, stable) bubble-sort sequencer driving a
// single-port synchronous-read RAM. Passes repeat, each one element shorter,
// until a pass performs no swap.
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   go                    : start request, sampled in IDLE and DONE
//   length                : element count, latched at start
//   mem_addr/rd/wr/wdata  : RAM interface (read data valid the cycle after rd)
//   mem_rdata             : RAM read data
//   busy                  : high in every state except IDLE and DONE
//   done                  : high in DONE until the next go
// Optional build macro BSORT_STATS_EN adds:
//   swap_count            : saturating count of swaps since start
//   pass_count            : number of passes started since start
// All outputs are registered: they are computed from the next state so
// they line up with the state they belong to.
// ---------------------------------------------------------------------------
module bubble_sort_control
  import bsort_pkg::*;
#(
  parameter int DATA_W = BSORT_DATA_W,
  parameter int ADDR_W = BSORT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
`ifdef BSORT_STATS_EN
  ,
  output logic [15:0]       swap_count,
  output logic [ADDR_W-1:0] pass_count
`endif
);

  state_e            state_q, state_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] elem_a_q, elem_a_d;
  logic [DATA_W-1:0] elem_b_q, elem_b_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ctr_load, ctr_next_pass, ctr_inc;
  logic [ADDR_W-1:0] idx, idx_nxt, limit;
  logic              last_pair, limit_gt2;

  bsort_index_ctr #(.ADDR_W(ADDR_W)) u_index_ctr (
    .clock     (clock),
    .reset     (reset),
    .load      (ctr_load),
    .next_pass (ctr_next_pass),
    .inc       (ctr_inc),
    .length    (length),
    .idx       (idx),
    .idx_nxt   (idx_nxt),
    .limit     (limit),
    .last_pair (last_pair),
    .limit_gt2 (limit_gt2)
  );

  // Next state, counter controls and element capture.
  always_comb begin
    state_d       = state_q;
    swapped_d     = swapped_q;
    elem_a_d      = elem_a_q;
    elem_b_d      = elem_b_q;
    ctr_load      = 1'b0;
    ctr_next_pass = 1'b0;
    ctr_inc       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_SETUP;
      S_SETUP: begin
        ctr_load  = 1'b1;
        swapped_d = 1'b0;
        state_d   = (length < ADDR_W'(MIN_SORT_LEN)) ? S_DONE : S_RD_A;
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        elem_a_d = mem_rdata;
        state_d  = S_CMP;
      end
      S_CMP: begin
        // Compare against the live read data; elem_b is captured in the
        // same edge. Strict '>' keeps equal elements in order.
        elem_b_d = mem_rdata;
        if (elem_a_q > mem_rdata) begin
          swapped_d = 1'b1;
          state_d   = S_WR_A;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_A: state_d = S_WR_B;
      S_WR_B: state_d = S_NEXT;
      S_NEXT: begin
        if (last_pair) begin
          state_d = S_PASS_END;
        end else begin
          ctr_inc = 1'b1;
          state_d = S_RD_A;
        end
      end
      S_PASS_END: begin
        if (swapped_q && limit_gt2) begin
          ctr_next_pass = 1'b1;
          swapped_d     = 1'b0;
          state_d       = S_RD_A;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, using the index value that state
  // will see. Address and write data stay 0 outside their states.
  always_comb begin
    mem_addr_d  = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = '0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    case (state_d)
      S_RD_A: begin
        mem_addr_d = idx_nxt;
        mem_rd_d   = 1'b1;
      end
      S_RD_B: begin
        mem_addr_d = idx_nxt + ADDR_W'(1);
        mem_rd_d   = 1'b1;
      end
      S_WR_A: begin
        mem_addr_d  = idx_nxt;
        mem_wdata_d = elem_b_d;
        mem_wr_d    = 1'b1;
      end
      S_WR_B: begin
        mem_addr_d  = idx_nxt + ADDR_W'(1);
        mem_wdata_d = elem_a_d;
        mem_wr_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every register here, element registers included, has an
  // asynchronous reset value so all outputs drop the moment reset asserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      swapped_q   <= 1'b0;
      elem_a_q    <= '0;
      elem_b_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      swapped_q   <= swapped_d;
      elem_a_q    <= elem_a_d;
      elem_b_q    <= elem_b_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef BSORT_STATS_EN
  logic [15:0]       swap_count_q, swap_count_d;
  logic [ADDR_W-1:0] pass_count_q, pass_count_d;

  // Cleared on entry to SETUP; a pass starts on every entry to RD_A with
  // idx=0 (only from SETUP or PASS_END, since NEXT always advances idx).
  always_comb begin
    swap_count_d = swap_count_q;
    pass_count_d = pass_count_q;
    if (state_d == S_SETUP) begin
      swap_count_d = '0;
      pass_count_d = '0;
    end else begin
      if ((state_d == S_WR_A) && (swap_count_q != 16'hFFFF))
        swap_count_d = swap_count_q + 16'd1;
      if ((state_d == S_RD_A) && (idx_nxt == '0))
        pass_count_d = pass_count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      swap_count_q <= '0;
      pass_count_q <= '0;
    end else begin
      swap_count_q <= swap_count_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign swap_count = swap_count_q;
  assign pass_count = pass_count_q;
`endif

endmodule

// File: tb/tb_bubble_sort_control.sv
// ---------------------------------------------------------------------------
// tb_bubble_sort_control
// Self-checking bench for bubble_sort_control with a behavioural RAM and a
// reference bubble sort computed on plain arrays.
// ---------------------------------------------------------------------------
module tb_bubble_sort_control;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int MAXN = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go    = 1'b0;
  logic [AW-1:0] length = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
`ifdef BSORT_STATS_EN
  logic [15:0]   swap_count;
  logic [AW-1:0] pass_count;
`endif

  bubble_sort_control #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
`ifdef BSORT_STATS_EN
    ,
    .swap_count(swap_count),
    .pass_count(pass_count)
`endif
  );

  always #5 clock = ~clock;

  // Single-port synchronous-read RAM.
  logic [DW-1:0] ram [256];
  always @(posedge clock) begin
    if (mem_wr) ram[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  // Bus monitor.
  int wr_cnt = 0, rd_cnt = 0, overlap = 0, idle_bad = 0;
  always @(negedge clock) begin
    if (mem_wr) wr_cnt++;
    if (mem_rd) rd_cnt++;
    if (mem_rd && mem_wr) overlap++;
    if (!mem_rd && !mem_wr && mem_addr != '0) idle_bad++;
    if (!mem_wr && mem_wdata != '0) idle_bad++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: textbook bubble sort with shrinking range and early exit.
  logic [DW-1:0] exp_a [MAXN];
  int m_edges, m_swaps, m_passes;

  task automatic model(input logic [DW-1:0] a_in [MAXN], input int n);
    int limit, cmps;
    bit sw;
    logic [DW-1:0] t;
    exp_a    = a_in;
    cmps     = 0;
    m_swaps  = 0;
    m_passes = 0;
    limit    = n;
    if (n >= 2) begin
      forever begin
        m_passes++;
        sw = 1'b0;
        for (int i = 0; i < limit - 1; i++) begin
          cmps++;
          if (exp_a[i] > exp_a[i+1]) begin
            t = exp_a[i]; exp_a[i] = exp_a[i+1]; exp_a[i+1] = t;
            m_swaps++;
            sw = 1'b1;
          end
        end
        if (sw && limit > 2) limit--;
        else break;
      end
    end
    // setup + 4 per compare + 2 per swap + 1 pass-end per pass
    m_edges = 1 + 4 * cmps + 2 * m_swaps + m_passes;
  endtask

  task automatic load(input logic [DW-1:0] a [MAXN], input int n);
    for (int i = 0; i < MAXN; i++) ram[i] = a[i];
    length = AW'(n);
  endtask

  int busy_drop;

  // Pulse go for one sampling edge, then count edges until done rises.
  task automatic run(output int edges);
    wr_cnt    = 0;
    rd_cnt    = 0;
    busy_drop = 0;
    @(negedge clock);
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
    edges = 0;
    while (edges < 20000) begin
      @(posedge clock);
      #1;
      edges++;
      if (done) break;
      if (!busy) busy_drop++;
    end
    if (!done) check("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic do_case(input string tag, input logic [DW-1:0] a [MAXN], input int n);
    int edges;
    model(a, n);
    load(a, n);
    run(edges);
    check({tag, "_edges"}, 32'(edges), 32'(m_edges));
    check({tag, "_writes"}, 32'(wr_cnt), 32'(2 * m_swaps));
    check({tag, "_busy"}, 32'(busy_drop), 32'd0);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ram%0d", tag, i), ram[i], exp_a[i]);
`ifdef BSORT_STATS_EN
    check({tag, "_swap_cnt"}, 32'(swap_count), 32'(m_swaps));
    check({tag, "_pass_cnt"}, 32'(pass_count), 32'(m_passes));
`endif
  endtask

  logic [DW-1:0] a [MAXN];
  int edges, k;

  initial begin
    // Reset state.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Already sorted.
    a = '{default: '0};
    a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4;
    do_case("sorted", a, 4);
    check("sorted_edges14", 32'(m_edges), 32'd14);
    check("sorted_rd", 32'(rd_cnt), 32'd6);

    // Reverse.
    a[0] = 4; a[1] = 3; a[2] = 2; a[3] = 1;
    do_case("reverse", a, 4);
    check("reverse_wr12", 32'(wr_cnt), 32'd12);

    // Degenerate lengths.
    do_case("len0", a, 0);
    check("len0_rd", 32'(rd_cnt), 32'd0);
    do_case("len1", a, 1);
    check("len1_rd", 32'(rd_cnt), 32'd0);

    // Duplicates and all-ones value.
    a = '{default: '0};
    a[0] = 5; a[1] = 5; a[2] = 2;
    do_case("dup", a, 3);
    a[0] = 32'hFFFF_FFFF; a[1] = 0; a[2] = 7; a[3] = 32'h8000_0000;
    do_case("maxval", a, 4);

    // Randomized arrays.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(2, 12);
      a = '{default: '0};
      for (int i = 0; i < n; i++)
        a[i] = (t % 2 == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      do_case($sformatf("rnd%0d", t), a, n);
    end

    // Reset asserted during WR_A.
    a = '{default: '0};
    a[0] = 4; a[1] = 3; a[2] = 2; a[3] = 1;
    load(a, 4);
    @(negedge clock);
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
    k = 0;
    while (!mem_wr && k < 200) begin
      @(posedge clock);
      #1 k++;
    end
    check("wr_a_reached", 32'(mem_wr), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_wr", 32'(mem_wr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_idle_done", 32'(done), 32'd0);
    a = '{default: '0};
    a[0] = 3; a[1] = 1;
    do_case("after_rst", a, 2);

    // go held through DONE; length changed mid-sort.
    a = '{default: '0};
    a[0] = 4; a[1] = 3; a[2] = 2; a[3] = 1;
    model(a, 4);
    load(a, 4);
    @(negedge clock);
    go = 1'b1;
    @(posedge clock);
    edges = 0;
    while (edges < 20000) begin
      @(posedge clock);
      #1 edges++;
      if (edges == 5) length = AW'(2);
      if (done) break;
    end
    check("held_edges", 32'(edges), 32'(m_edges));
    for (int i = 0; i < 4; i++) check($sformatf("held_ram%0d", i), ram[i], exp_a[i]);
    @(posedge clock);
    #1;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    go = 1'b0;
    edges = 0;
    while (edges < 20000) begin
      @(posedge clock);
      #1 edges++;
      if (done) break;
    end
    // Restart sorts the first two elements only: 1 compare, 1 pass.
    check("restart_edges", 32'(edges), 32'd6);
    for (int i = 0; i < 4; i++) check($sformatf("restart_ram%0d", i), ram[i], exp_a[i]);

    check("rd_wr_overlap", 32'(overlap), 32'd0);
    check("idle_bus_nonzero", 32'(idle_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
